// File: rtl/tdm_mux_scanner_pkg.sv
// Shared types and constants for the TDM mux/scanner block.
package tdm_mux_scanner_pkg;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_MANUAL = 2'b01,
    ST_SCAN   = 2'b10
  } state_t;

  // Values of the mode input.
  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Width of a counter holding 0..n-1. The result is never below 1, so a
  // single-value count still has a legal vector width.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tdm_mux_scanner_if.sv
// Channel data, control and tagged-sample bus of the TDM mux/scanner.
// The master side drives the channels and controls. The slave side is the
// scanner, which returns the registered sample and its status.
interface tdm_mux_scanner_if #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 1
);
  localparam int SEL_W = $clog2(N_CH);

  logic [N_CH*WIDTH-1:0] d;          // packed channels, channel k at d[k*WIDTH +: WIDTH]
  logic [SEL_W-1:0]      sel;        // manual-mode channel select
  logic                  mode;       // 0 = manual, 1 = scan
  logic                  start;      // scan start pulse
  logic                  stop;       // scan abort
  logic [WIDTH-1:0]      z;          // registered sample
  logic [SEL_W-1:0]      z_ch;       // channel the sample came from
  logic                  z_valid;    // z/z_ch are valid
  logic                  frame_done; // last channel of a scan frame is on z
  logic                  busy;       // scanning

  modport master (
    output d, sel, mode, start, stop,
    input  z, z_ch, z_valid, frame_done, busy
  );

  modport slave (
    input  d, sel, mode, start, stop,
    output z, z_ch, z_valid, frame_done, busy
  );

endinterface

// File: rtl/tdm_mux_scanner_mux_n.sv
// Purely combinational N:1 slice multiplexer. An index at or above N_CH
// returns zero and raises out_of_range. This can only occur when N_CH is
// not a power of two.
module tdm_mux_scanner_mux_n #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 1,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH*WIDTH-1:0] d,
  input  logic [SEL_W-1:0]      sel,
  output logic [WIDTH-1:0]      y,
  output logic                  out_of_range
);

  // Choose the slice whose index matches sel. No match means out of range.
  always_comb begin
    // NOTE: every output gets a default before the loop. Without it, an
    // unmatched sel would leave y holding its old value, and synthesis
    // would infer a latch.
    y            = '0;
    out_of_range = 1'b1;
    for (int k = 0; k < N_CH; k++) begin
      if (sel == SEL_W'(k)) begin
        y            = d[k*WIDTH +: WIDTH];
        out_of_range = 1'b0;
      end
    end
  end

endmodule

// File: rtl/tdm_mux_scanner.sv
// Registered N-channel multiplexer with two modes.
//  - Manual mode: a registered N:1 mux, with one cycle from sel to z.
//  - Scan mode: a time-division walk over every channel, DWELL cycles per
//    channel. Each sample carries its channel tag.
// A start pulse is captured in IDLE and acted on one edge later. The first
// scan sample therefore appears two edges after start, and busy rises one
// edge after start. stop acts on the edge where it is sampled. That edge
// loads no sample. All outputs come straight from flops.
module tdm_mux_scanner
  import tdm_mux_scanner_pkg::*;
#(
  parameter int N_CH  = 4,   // number of channels, >= 2
  parameter int WIDTH = 1,   // bits per channel
  parameter int DWELL = 1    // cycles per channel in scan mode, >= 1
) (
  input  logic             clk,
  input  logic             rst,
  tdm_mux_scanner_if.slave bus  // must be built with the same N_CH/WIDTH
);

  localparam int SEL_W = $clog2(N_CH);
  localparam int DW_W  = cnt_width(DWELL);

  localparam logic [SEL_W-1:0] CH_LAST    = SEL_W'(N_CH - 1);
  localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL - 1);

  state_t           state_q, state_d;
  logic             start_q, start_d;
  logic [SEL_W-1:0] ch_q, ch_d;
  logic [DW_W-1:0]  dwell_q, dwell_d;
  logic [WIDTH-1:0] z_q, z_d;
  logic [SEL_W-1:0] z_ch_q, z_ch_d;
  logic             z_valid_q, z_valid_d;
  logic             frame_done_q, frame_done_d;

  logic [SEL_W-1:0] mux_sel;
  logic [WIDTH-1:0] mux_y;
  logic             mux_oor;
  logic             last_ch;
  logic             last_dwell;

  // One shared mux. The scan counter steers it while scanning, and the
  // manual select steers it otherwise.
  assign mux_sel = (state_q == ST_SCAN) ? ch_q : bus.sel;

  tdm_mux_scanner_mux_n #(
    .N_CH  (N_CH),
    .WIDTH (WIDTH),
    .SEL_W (SEL_W)
  ) u_mux (
    .d            (bus.d),
    .sel          (mux_sel),
    .y            (mux_y),
    .out_of_range (mux_oor)
  );

  assign last_ch    = (ch_q == CH_LAST);
  assign last_dwell = (dwell_q == DWELL_LAST);

  // Next-state, counter and output-register logic for all three states.
  always_comb begin
    state_d      = state_q;
    start_d      = 1'b0;
    ch_d         = ch_q;
    dwell_d      = dwell_q;
    z_d          = z_q;
    z_ch_d       = z_ch_q;
    z_valid_d    = 1'b0;
    frame_done_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Capture a start only when stop is not also asserted, so that stop
        // wins a tie. Check stop again when acting on the captured start.
        start_d = (bus.mode == MODE_SCAN) && bus.start && !bus.stop;
        if (start_q && (bus.mode == MODE_SCAN) && !bus.stop) begin
          state_d = ST_SCAN;
          start_d = 1'b0;
          ch_d    = '0;
          dwell_d = '0;
        end else if (bus.mode == MODE_MANUAL) begin
          state_d = ST_MANUAL;
        end
      end

      ST_MANUAL: begin
        if (bus.mode == MODE_SCAN) begin
          // Leave manual mode. z and z_ch keep their values, and the
          // sample is marked invalid from the next cycle.
          state_d = ST_IDLE;
        end else begin
          // The mux already returns zero for an index that is out of range.
          z_d       = mux_y;
          z_ch_d    = bus.sel;
          z_valid_d = !mux_oor;
        end
      end

      ST_SCAN: begin
        if (bus.stop) begin
          // Abort. This cycle's sample is dropped and the counters are left
          // as they are, because the next start clears them.
          state_d = ST_IDLE;
        end else begin
          z_d          = mux_y;
          z_ch_d       = ch_q;
          z_valid_d    = 1'b1;
          frame_done_d = last_ch && last_dwell;
          if (last_dwell) begin
            dwell_d = '0;
            ch_d    = last_ch ? '0 : ch_q + SEL_W'(1);
          end else begin
            dwell_d = dwell_q + DW_W'(1);
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State register. A synchronous reset returns the controller to IDLE.
  always_ff @(posedge clk) begin
    // NOTE: flops use non-blocking assignment. All of them then update
    // together at the edge, whatever order the statements appear in.
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Counters, start capture and output registers. Reset clears them even
  // in the middle of a scan.
  always_ff @(posedge clk) begin
    if (rst) begin
      start_q      <= 1'b0;
      ch_q         <= '0;
      dwell_q      <= '0;
      z_q          <= '0;
      z_ch_q       <= '0;
      z_valid_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      start_q      <= start_d;
      ch_q         <= ch_d;
      dwell_q      <= dwell_d;
      z_q          <= z_d;
      z_ch_q       <= z_ch_d;
      z_valid_q    <= z_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.z          = z_q;
  assign bus.z_ch       = z_ch_q;
  assign bus.z_valid    = z_valid_q;
  assign bus.frame_done = frame_done_q;
  assign bus.busy       = (state_q == ST_SCAN);

endmodule

// File: tb/tb_tdm_mux_scanner.sv
// Directed bench for tdm_mux_scanner. Three instances share one stimulus:
//  - A: N_CH=4, DWELL=1
//  - B: N_CH=4, DWELL=3
//  - C: N_CH=3, DWELL=1
// d is 4'b1010, so channel k of A and B carries k[0]. C sees 3'b010, so
// only its channel 1 carries a 1.
module tb_tdm_mux_scanner;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] d;
  logic [1:0] sel;
  logic       mode;
  logic       start;
  logic       stop;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tdm_mux_scanner_if #(.N_CH(4), .WIDTH(1)) bus_a ();
  tdm_mux_scanner_if #(.N_CH(4), .WIDTH(1)) bus_b ();
  tdm_mux_scanner_if #(.N_CH(3), .WIDTH(1)) bus_c ();

  assign bus_a.d = d;       assign bus_b.d = d;       assign bus_c.d = d[2:0];
  assign bus_a.sel = sel;   assign bus_b.sel = sel;   assign bus_c.sel = sel;
  assign bus_a.mode = mode; assign bus_b.mode = mode; assign bus_c.mode = mode;
  assign bus_a.start = start; assign bus_b.start = start; assign bus_c.start = start;
  assign bus_a.stop = stop; assign bus_b.stop = stop; assign bus_c.stop = stop;

  tdm_mux_scanner #(.N_CH(4), .WIDTH(1), .DWELL(1)) u_dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  tdm_mux_scanner #(.N_CH(4), .WIDTH(1), .DWELL(3)) u_dut_b (.clk(clk), .rst(rst), .bus(bus_b));
  tdm_mux_scanner #(.N_CH(3), .WIDTH(1), .DWELL(1)) u_dut_c (.clk(clk), .rst(rst), .bus(bus_c));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_a(input string tag, input int ez, input int ech, input int ev,
                         input int efd, input int eb);
    check({tag, " a.z"},          32'(bus_a.z),          32'(ez));
    check({tag, " a.z_ch"},       32'(bus_a.z_ch),       32'(ech));
    check({tag, " a.z_valid"},    32'(bus_a.z_valid),    32'(ev));
    check({tag, " a.frame_done"}, 32'(bus_a.frame_done), 32'(efd));
    check({tag, " a.busy"},       32'(bus_a.busy),       32'(eb));
  endtask

  task automatic check_b(input string tag, input int ez, input int ech, input int ev,
                         input int efd, input int eb);
    check({tag, " b.z"},          32'(bus_b.z),          32'(ez));
    check({tag, " b.z_ch"},       32'(bus_b.z_ch),       32'(ech));
    check({tag, " b.z_valid"},    32'(bus_b.z_valid),    32'(ev));
    check({tag, " b.frame_done"}, 32'(bus_b.frame_done), 32'(efd));
    check({tag, " b.busy"},       32'(bus_b.busy),       32'(eb));
  endtask

  task automatic check_c(input string tag, input int ez, input int ech, input int ev,
                         input int efd, input int eb);
    check({tag, " c.z"},          32'(bus_c.z),          32'(ez));
    check({tag, " c.z_ch"},       32'(bus_c.z_ch),       32'(ech));
    check({tag, " c.z_valid"},    32'(bus_c.z_valid),    32'(ev));
    check({tag, " c.frame_done"}, 32'(bus_c.frame_done), 32'(efd));
    check({tag, " c.busy"},       32'(bus_c.busy),       32'(eb));
  endtask

  initial begin
    int ch_a, ch_b, ch_c;

    // Reset for two edges: every output is cleared.
    rst = 1'b1; d = 4'b1010; sel = 2'd0; mode = 1'b0; start = 1'b0; stop = 1'b0;
    tick(); tick();
    check_a("reset", 0, 0, 0, 0, 0);
    check_b("reset", 0, 0, 0, 0, 0);
    check_c("reset", 0, 0, 0, 0, 0);

    // IDLE -> MANUAL. Nothing has been loaded yet.
    rst = 1'b0;
    tick();
    check_a("enter_manual", 0, 0, 0, 0, 0);

    // Manual mode: sel = 0..3 gives z = 0,1,0,1. On C, sel=3 is out of range.
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      tick();
      check_a($sformatf("manual[%0d]", i), i % 2, i, 1, 0, 0);
      check_b($sformatf("manual[%0d]", i), i % 2, i, 1, 0, 0);
      if (i < 3) check_c($sformatf("manual[%0d]", i), (i == 1) ? 1 : 0, i, 1, 0, 0);
      else       check_c("manual_oor", 0, 3, 0, 0, 0);
    end

    // mode=1 leaves MANUAL. Valid drops and z/z_ch keep their values.
    mode = 1'b1;
    tick();
    check_a("manual_exit", 1, 3, 0, 0, 0);
    check_c("manual_exit", 0, 3, 0, 0, 0);

    // Start pulse at edge T. busy is still low right after T.
    start = 1'b1;
    tick();
    start = 1'b0;
    check_a("start_T", 1, 3, 0, 0, 0);

    // After T+1: busy is high but there is no sample yet.
    tick();
    check_a("start_T1", 1, 3, 0, 0, 1);
    check_b("start_T1", 1, 3, 0, 0, 1);

    // From T+2 onward: the scan walk. Dropping mode at k=6 must not disturb it.
    for (int k = 0; k < 13; k++) begin
      if (k == 6) mode = 1'b0;
      tick();
      ch_a = k % 4;
      ch_b = (k / 3) % 4;
      ch_c = k % 3;
      check_a($sformatf("scan[%0d]", k), ch_a % 2, ch_a, 1, (ch_a == 3) ? 1 : 0, 1);
      check_b($sformatf("scan[%0d]", k), ch_b % 2, ch_b, 1, (k % 12 == 11) ? 1 : 0, 1);
      check_c($sformatf("scan[%0d]", k), (ch_c == 1) ? 1 : 0, ch_c, 1, (ch_c == 2) ? 1 : 0, 1);
    end

    // Abort mid-frame. No sample is loaded, busy drops, and z keeps the
    // value loaded from channel 0.
    mode = 1'b1;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_a("stop", 0, 0, 0, 0, 0);
    check_b("stop", 0, 0, 0, 0, 0);
    check_c("stop", 0, 0, 0, 0, 0);

    // start and stop together in IDLE: stop wins and no scan begins.
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    tick(); tick();
    check_a("start_stop", 0, 0, 0, 0, 0);
    check_c("start_stop", 0, 0, 0, 0, 0);

    // Start a new scan and let the first two samples load.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check_a("rescan_T1", 0, 0, 0, 0, 1);
    tick();
    check_a("rescan[0]", 0, 0, 1, 0, 1);
    tick();
    check_a("rescan[1]", 1, 1, 1, 0, 1);
    check_b("rescan[1]", 0, 0, 1, 0, 1);
    check_c("rescan[1]", 1, 1, 1, 0, 1);

    // Reset for two edges in the middle of the scan clears everything.
    rst = 1'b1;
    tick(); tick();
    check_a("reset_mid", 0, 0, 0, 0, 0);
    check_b("reset_mid", 0, 0, 0, 0, 0);
    check_c("reset_mid", 0, 0, 0, 0, 0);

    // After release with mode=1 and no new start, the block stays IDLE.
    rst = 1'b0;
    tick();
    check_a("post_reset", 0, 0, 0, 0, 0);
    tick();
    check_a("post_reset2", 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
